// File: rtl/lsu_mem_ctrl_if.sv
// Request/response and data-memory bus of the load/store sequencer.
// master: execute stage plus data memory; slave: the lsu_mem_ctrl controller.
interface lsu_mem_ctrl_if #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) ();
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;

  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_error;

  logic [ADDR_W-1:0] mem_address;
  logic [XLEN-1:0]   mem_write_data;
  logic              mem_read;
  logic              mem_write;
  logic [XLEN-1:0]   mem_read_data;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    input  req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_read, mem_write
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_read_data,
    output req_ready, resp_valid, resp_rdata, resp_error,
           mem_address, mem_write_data, mem_read, mem_write
  );
endinterface

// File: rtl/lsu_mem_ctrl.sv
// RV64I load/store sequencer for a 64-bit single-port data memory with 1-cycle reads.
// Sub-doubleword stores are read-modify-write; illegal or misaligned requests trap without memory access.
module lsu_mem_ctrl #(
  parameter int ADDR_W = 64,
  parameter int XLEN   = 64
) (
  input  logic           clk,
  input  logic           rst,
  lsu_mem_ctrl_if.slave  bus
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_RD    = 3'd1;
  localparam logic [2:0] S_LDFMT = 3'd2;
  localparam logic [2:0] S_WR    = 3'd3;
  localparam logic [2:0] S_MERGE = 3'd4;
  localparam logic [2:0] S_RESP  = 3'd5;

  logic [2:0]        state, state_next;
  logic              we_q;
  logic [2:0]        funct3_q;
  logic [ADDR_W-1:0] addr_q;
  logic [XLEN-1:0]   wdata_q;

  logic              accept;
  logic              req_misaligned;
  logic              req_illegal;
  logic              req_bad;

  logic [ADDR_W-1:0] aligned_addr;
  logic [5:0]        bit_off;
  logic [XLEN-1:0]   ld_shift;
  logic [XLEN-1:0]   ld_fmt;
  logic [7:0]        lane_mask;
  logic [7:0]        lane_sel;
  logic [XLEN-1:0]   bit_mask;
  logic [XLEN-1:0]   st_shift;
  logic [XLEN-1:0]   merged;

  assign accept = bus.req_valid && bus.req_ready;

  // Legality is judged on the live request so a trap can go straight to RESP.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path infers a latch.
    req_misaligned = 1'b0;
    case (bus.req_funct3[1:0])
      2'b01:   req_misaligned = bus.req_addr[0];
      2'b10:   req_misaligned = |bus.req_addr[1:0];
      2'b11:   req_misaligned = |bus.req_addr[2:0];
      default: req_misaligned = 1'b0;
    endcase
  end

  assign req_illegal = bus.req_we ? bus.req_funct3[2] : (bus.req_funct3 == 3'b111);
  assign req_bad     = req_illegal || req_misaligned;

  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept) begin
          if (req_bad)                        state_next = S_RESP;
          else if (!bus.req_we)               state_next = S_RD;
          else if (bus.req_funct3[1:0] == 2'b11) state_next = S_WR;
          else                                state_next = S_RD;
        end
      end
      S_RD:    state_next = we_q ? S_MERGE : S_LDFMT;
      S_LDFMT: state_next = S_RESP;
      S_WR:    state_next = S_RESP;
      S_MERGE: state_next = S_RESP;
      S_RESP:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  assign aligned_addr = {addr_q[ADDR_W-1:3], 3'b000};
  assign bit_off      = {addr_q[2:0], 3'b000};

  // Load formatting: bring the addressed bytes down to bit 0, then extend.
  assign ld_shift = bus.mem_read_data >> bit_off;

  always_comb begin
    ld_fmt = ld_shift;
    case (funct3_q)
      3'b000:  ld_fmt = {{(XLEN-8){ld_shift[7]}},   ld_shift[7:0]};
      3'b001:  ld_fmt = {{(XLEN-16){ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_fmt = {{(XLEN-32){ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_fmt = {{(XLEN-8){1'b0}},          ld_shift[7:0]};
      3'b101:  ld_fmt = {{(XLEN-16){1'b0}},         ld_shift[15:0]};
      3'b110:  ld_fmt = {{(XLEN-32){1'b0}},         ld_shift[31:0]};
      default: ld_fmt = ld_shift;
    endcase
  end

  // Store merge: byte-lane mask placed at the offset; alignment keeps it inside the doubleword.
  always_comb begin
    lane_mask = 8'h01;
    case (funct3_q[1:0])
      2'b00:   lane_mask = 8'h01;
      2'b01:   lane_mask = 8'h03;
      2'b10:   lane_mask = 8'h0F;
      default: lane_mask = 8'hFF;
    endcase
  end

  assign lane_sel = lane_mask << addr_q[2:0];

  always_comb begin
    bit_mask = '0;
    for (int i = 0; i < 8; i++) begin
      bit_mask[8*i +: 8] = {8{lane_sel[i]}};
    end
  end

  assign st_shift = wdata_q << bit_off;
  assign merged   = (bus.mem_read_data & ~bit_mask) | (st_shift & bit_mask);

  assign bus.req_ready      = (state == S_IDLE);
  // Strobes are gated by rst so a reset landing mid-operation never writes.
  assign bus.mem_read       = !rst && (state == S_RD);
  assign bus.mem_write      = !rst && ((state == S_WR) || (state == S_MERGE));
  assign bus.mem_address    = (state == S_IDLE) ? '0 : aligned_addr;
  assign bus.mem_write_data = (state == S_MERGE) ? merged :
                              (state == S_WR)    ? wdata_q : '0;

  // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= S_IDLE;
      we_q           <= 1'b0;
      funct3_q       <= 3'b000;
      addr_q         <= '0;
      wdata_q        <= '0;
      bus.resp_valid <= 1'b0;
      bus.resp_rdata <= '0;
      bus.resp_error <= 1'b0;
    end else begin
      state          <= state_next;
      bus.resp_valid <= (state_next == S_RESP);

      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
        if (req_bad) begin
          bus.resp_error <= 1'b1;
          bus.resp_rdata <= '0;
        end
      end

      case (state)
        S_LDFMT: begin
          bus.resp_rdata <= ld_fmt;
          bus.resp_error <= 1'b0;
        end
        S_WR, S_MERGE: begin
          bus.resp_rdata <= '0;
          bus.resp_error <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  a_no_rd_wr_overlap: assert property (@(posedge clk) !(bus.mem_read && bus.mem_write));
  a_resp_one_cycle:   assert property (@(posedge clk) disable iff (rst)
                                       bus.resp_valid |=> !bus.resp_valid);

endmodule
